tmds_encoder: RTL and testbench

//  Downstream stage of the 640x480p60 timing/pattern generator. Takes pixel-rate DE, HSYNC, VSYNC and 8-bit RGB.

---
 rtl/tmds_encoder.sv | 218 +++++++++++++++++++++
 tb/tb_tmds_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_encoder
//  Purpose  : DVI/HDMI TMDS encoder for three channels (ch0=blue+sync,
//             ch1=green, ch2=red). 2-clock latency. Defining
//             HDMI_VIDEO_GUARD_EN adds HDMI video preamble/guard-band insertion.
//  Revision : 1.0 - initial release
// ============================================================================
module tmds_encoder #(
    parameter int         PREAMBLE_LEN = 8,
    parameter int         GUARD_LEN    = 2,
    parameter logic [2:0] INVERT_CH    = 3'b000
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic       data_enable,
    input  logic       horz_sync,
    input  logic       vert_sync,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2,
    output logic       tmds_de
);

    localparam logic [9:0] c_CTL_00   = 10'b1101010100;
    localparam logic [9:0] c_CTL_01   = 10'b0010101011;
    localparam logic [9:0] c_CTL_10   = 10'b0101010100;
    localparam logic [9:0] c_CTL_11   = 10'b1010101011;
    localparam logic [9:0] c_GUARD_02 = 10'b1011001100;
    localparam logic [9:0] c_GUARD_1  = 10'b0100110011;
    localparam logic [9:0] c_RST_CH0  = c_CTL_00 ^ {10{INVERT_CH[0]}};
    localparam logic [9:0] c_RST_CH1  = c_CTL_00 ^ {10{INVERT_CH[1]}};
    localparam logic [9:0] c_RST_CH2  = c_CTL_00 ^ {10{INVERT_CH[2]}};

    // The countdown and delay line need at least one preamble and one guard pixel.
    if (PREAMBLE_LEN < 1 || GUARD_LEN < 1) begin : g_bad_len
        $error("tmds_encoder: PREAMBLE_LEN and GUARD_LEN must be >= 1");
    end

    function automatic logic [8:0] f_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, d[i]};
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q    = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Returns {symbol[9:0], next disparity[4:0]}; disparity is 5b two's complement.
    function automatic logic [14:0] f_balance(input logic [8:0] qm, input logic [4:0] cnt);
        logic [4:0] n1;
        logic [4:0] n0;
        logic [9:0] sym;
        logic [4:0] nxt;
        n1 = 5'd0;
        for (int i = 0; i < 8; i++) n1 = n1 + {4'b0000, qm[i]};
        n0 = 5'd8 - n1;
        if ((cnt == 5'd0) || (n1 == n0)) begin
            sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            nxt = qm[8] ? (cnt + n1 - n0) : (cnt + n0 - n1);
        end else if ((!cnt[4] && (n1 > n0)) || (cnt[4] && (n0 > n1))) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = cnt + {3'b000, qm[8], 1'b0} + n0 - n1;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = cnt - {3'b000, ~qm[8], 1'b0} + n1 - n0;
        end
        return {sym, nxt};
    endfunction

    function automatic logic [9:0] f_ctl(input logic [1:0] c);
        case (c)
            2'b00:   return c_CTL_00;
            2'b01:   return c_CTL_01;
            2'b10:   return c_CTL_10;
            default: return c_CTL_11;
        endcase
    endfunction

    logic       w_de, w_hs, w_vs;
    logic [7:0] w_red, w_green, w_blue;
    logic       w_preamble, w_guard;

`ifdef HDMI_VIDEO_GUARD_EN
    localparam int              c_DLY     = PREAMBLE_LEN + GUARD_LEN;
    localparam int              c_CW      = $clog2(c_DLY + 1);
    localparam logic [c_CW-1:0] c_DLY_V   = c_CW'(c_DLY);
    localparam logic [c_CW-1:0] c_GUARD_V = c_CW'(GUARD_LEN);
    localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);

    logic [26:0]     dly_q [c_DLY];
    logic [26:0]     dly_d [c_DLY];
    logic            de_prev_q, de_prev_d;
    logic [c_CW-1:0] countdown_q, countdown_d;

    // The countdown is already aligned to stage 2: it reads c_DLY in the cycle
    // that produces the first preamble symbol and reaches 0 when the pixel arrives.
    always_comb begin
        dly_d[0] = {data_enable, horz_sync, vert_sync, red, green, blue};
        for (int i = 1; i < c_DLY; i++) dly_d[i] = dly_q[i-1];
        de_prev_d   = data_enable;
        countdown_d = countdown_q;
        if (data_enable && !de_prev_q)  countdown_d = c_DLY_V;
        else if (countdown_q != '0)     countdown_d = countdown_q - c_ONE;
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DLY; i++) dly_q[i] <= '0;
            de_prev_q   <= 1'b0;
            countdown_q <= '0;
        end else begin
            for (int i = 0; i < c_DLY; i++) dly_q[i] <= dly_d[i];
            de_prev_q   <= de_prev_d;
            countdown_q <= countdown_d;
        end
    end

    assign {w_de, w_hs, w_vs, w_red, w_green, w_blue} = dly_q[c_DLY-1];
    assign w_preamble = (countdown_q > c_GUARD_V);
    assign w_guard    = (countdown_q != '0) && (countdown_q <= c_GUARD_V);
`else
    assign {w_de, w_hs, w_vs, w_red, w_green, w_blue} =
           {data_enable, horz_sync, vert_sync, red, green, blue};
    assign w_preamble = 1'b0;
    assign w_guard    = 1'b0;
`endif

    logic [8:0]  qm0_q, qm1_q, qm2_q, qm0_d, qm1_d, qm2_d;
    logic        de1_q, de1_d;
    logic [1:0]  ctl1_q, ctl1_d;
    logic [4:0]  cnt0_q, cnt1_q, cnt2_q, cnt0_d, cnt1_d, cnt2_d;
    logic [9:0]  ch0_q, ch1_q, ch2_q, ch0_d, ch1_d, ch2_d;
    logic        tmds_de_q, tmds_de_d;
    logic [9:0]  enc0, enc1, enc2;
    logic [14:0] w_bal0, w_bal1, w_bal2;

    always_comb begin
        qm0_d  = f_qm(w_blue);
        qm1_d  = f_qm(w_green);
        qm2_d  = f_qm(w_red);
        de1_d  = w_de;
        ctl1_d = {w_vs, w_hs};
    end

    assign w_bal0 = f_balance(qm0_q, cnt0_q);
    assign w_bal1 = f_balance(qm1_q, cnt1_q);
    assign w_bal2 = f_balance(qm2_q, cnt2_q);

    always_comb begin
        enc0   = f_ctl(ctl1_q);
        enc1   = c_CTL_00;
        enc2   = c_CTL_00;
        cnt0_d = 5'd0;
        cnt1_d = 5'd0;
        cnt2_d = 5'd0;
        if (w_guard) begin
            enc0 = c_GUARD_02;
            enc1 = c_GUARD_1;
            enc2 = c_GUARD_02;
        end else if (w_preamble) begin
            enc1 = c_CTL_01;
        end else if (de1_q) begin
            {enc0, cnt0_d} = w_bal0;
            {enc1, cnt1_d} = w_bal1;
            {enc2, cnt2_d} = w_bal2;
        end
        ch0_d     = enc0 ^ {10{INVERT_CH[0]}};
        ch1_d     = enc1 ^ {10{INVERT_CH[1]}};
        ch2_d     = enc2 ^ {10{INVERT_CH[2]}};
        tmds_de_d = de1_q;
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            qm0_q     <= '0;
            qm1_q     <= '0;
            qm2_q     <= '0;
            de1_q     <= 1'b0;
            ctl1_q    <= 2'b00;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            ch0_q     <= c_RST_CH0;
            ch1_q     <= c_RST_CH1;
            ch2_q     <= c_RST_CH2;
            tmds_de_q <= 1'b0;
        end else begin
            qm0_q     <= qm0_d;
            qm1_q     <= qm1_d;
            qm2_q     <= qm2_d;
            de1_q     <= de1_d;
            ctl1_q    <= ctl1_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            ch0_q     <= ch0_d;
            ch1_q     <= ch1_d;
            ch2_q     <= ch2_d;
            tmds_de_q <= tmds_de_d;
        end
    end

    assign tmds_ch0 = ch0_q;
    assign tmds_ch1 = ch1_q;
    assign tmds_ch2 = ch2_q;
    assign tmds_de  = tmds_de_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_encoder
//  Purpose  : Self-checking bench for tmds_encoder: constant vector table,
//             hand sequences and a randomized frame against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_encoder;

`ifdef HDMI_VIDEO_GUARD_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 2;
`endif
    localparam int MAXC = 8192;
    localparam logic [9:0] CTL00 = 10'b1101010100;
    localparam logic [9:0] CTL01 = 10'b0010101011;
    localparam logic [9:0] CTL10 = 10'b0101010100;
    localparam logic [9:0] CTL11 = 10'b1010101011;
    localparam logic [9:0] GB02  = 10'b1011001100;
    localparam logic [9:0] GB1   = 10'b0100110011;

    logic       clk;
    logic       reset;
    logic       de, hs, vs;
    logic [7:0] r, g, b;
    logic [9:0] ch0, ch1, ch2, inv0, inv1, inv2;
    logic       tde, inv_de;

    initial clk = 1'b0;
    always #20 clk = ~clk;

    tmds_encoder u_dut (
        .pixel_clock(clk), .reset(reset), .data_enable(de),
        .horz_sync(hs), .vert_sync(vs), .red(r), .green(g), .blue(b),
        .tmds_ch0(ch0), .tmds_ch1(ch1), .tmds_ch2(ch2), .tmds_de(tde)
    );

    tmds_encoder #(.INVERT_CH(3'b010)) u_inv (
        .pixel_clock(clk), .reset(reset), .data_enable(de),
        .horz_sync(hs), .vert_sync(vs), .red(r), .green(g), .blue(b),
        .tmds_ch0(inv0), .tmds_ch1(inv1), .tmds_ch2(inv2), .tmds_de(inv_de)
    );

    typedef struct {
        logic       de, hs, vs;
        logic [7:0] r, g, b;
        logic [9:0] e0, e1, e2;
        logic       ede;
    } vec_t;

    vec_t       tbl [7];
    logic [9:0] e0_a [MAXC];
    logic [9:0] e1_a [MAXC];
    logic [9:0] e2_a [MAXC];
    logic       ede_a [MAXC];
    bit         ev_a [MAXC];
    logic [9:0] ctl_tab [4];
    int         cyc, n_vec, n_err;
    int         mc0, mc1, mc2;
    logic       prev_de;

    task automatic chk10(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Drive one input cycle; record what its output slot must show; check the
    // slot that becomes visible after this clock.
    task automatic drive(input logic i_de, input logic i_hs, input logic i_vs,
                         input logic [7:0] i_r, input logic [7:0] i_g, input logic [7:0] i_b,
                         input bit chk, input logic [9:0] x0, input logic [9:0] x1,
                         input logic [9:0] x2, input logic xde);
        int s;
        de = i_de; hs = i_hs; vs = i_vs; r = i_r; g = i_g; b = i_b;
        ev_a[cyc] = chk; e0_a[cyc] = x0; e1_a[cyc] = x1; e2_a[cyc] = x2; ede_a[cyc] = xde;
`ifdef HDMI_VIDEO_GUARD_EN
        if (i_de && !prev_de && cyc >= LAT - 2) begin
            for (int k = 0; k < LAT - 2; k++) begin
                s = cyc - (LAT - 2) + k;
                if (k < LAT - 4) begin
                    e1_a[s] = CTL01; e2_a[s] = CTL00;
                end else begin
                    e0_a[s] = GB02; e1_a[s] = GB1; e2_a[s] = GB02;
                end
            end
        end
`endif
        prev_de = i_de;
        @(posedge clk); #1;
        s = cyc - LAT + 1;
        if (s >= 0 && ev_a[s]) begin
            chk10("ch0", ch0, e0_a[s]);
            chk10("ch1", ch1, e1_a[s]);
            chk10("ch2", ch2, e2_a[s]);
            chk10("de", {9'd0, tde}, {9'd0, ede_a[s]});
        end
        cyc++;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, CTL00, CTL00, CTL00, 0);
    endtask

    // Reference model: popcount-driven chain choice, then running-disparity
    // correction, computed directly with integers.
    task automatic m_encode(input logic [7:0] d, inout int cnt, output logic [9:0] sym);
        int   ones_d, n1, q8;
        bit   flip;
        logic [8:0] q;
        ones_d = $countones(d);
        flip = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
        q = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ flip;
        q[8] = !flip;
        q8 = flip ? 0 : 1;
        n1 = $countones(q[7:0]);
        if (cnt == 0 || n1 == 4) begin
            sym = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
            cnt = cnt + (q8 == 1 ? 2 * n1 - 8 : 8 - 2 * n1);
        end else if ((cnt > 0 && n1 > 4) || (cnt < 0 && n1 < 4)) begin
            sym = {1'b1, q[8], ~q[7:0]};
            cnt = cnt + 2 * q8 + 8 - 2 * n1;
        end else begin
            sym = {1'b0, q[8], q[7:0]};
            cnt = cnt - 2 * (1 - q8) + 2 * n1 - 8;
        end
    endtask

    function automatic logic [7:0] rnd_pix();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic mid_reset();
        #5 reset = 1'b1;
        #1;
        chk10("async_rst_ch0", ch0, CTL00);
        chk10("async_rst_ch1", ch1, CTL00);
        chk10("async_rst_ch2", ch2, CTL00);
        chk10("async_rst_de", {9'd0, tde}, 10'd0);
        for (int s = 0; s < MAXC; s++) ev_a[s] = 1'b0;
        mc0 = 0; mc1 = 0; mc2 = 0;
        prev_de = 1'b0;
        blank(3);
        reset = 1'b0;
    endtask

    task automatic run_frame(input int lines, input int act, input int blk, input int rst_line);
        logic [7:0] rr, gg, bb;
        logic [9:0] x0, x1, x2;
        logic       hsv, vsv;
        for (int l = 0; l < lines; l++) begin
            vsv = (l < 2);
            for (int p = 0; p < blk; p++) begin
                hsv = (p >= 4 && p < 12);
                mc0 = 0; mc1 = 0; mc2 = 0;
                drive(0, hsv, vsv, 8'h00, 8'h00, 8'h00, 1, ctl_tab[{vsv, hsv}], CTL00, CTL00, 0);
            end
            for (int p = 0; p < act; p++) begin
                if (l == rst_line && p == act / 2) mid_reset();
                rr = rnd_pix(); gg = rnd_pix(); bb = rnd_pix();
                m_encode(bb, mc0, x0);
                m_encode(gg, mc1, x1);
                m_encode(rr, mc2, x2);
                drive(1, 0, vsv, rr, gg, bb, 1, x0, x1, x2, 1);
            end
        end
    endtask

    initial begin
        #(MAXC * 80);
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_tab[0] = CTL00; ctl_tab[1] = CTL01; ctl_tab[2] = CTL10; ctl_tab[3] = CTL11;
        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, CTL01, CTL00, CTL00, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, CTL10, CTL00, CTL00, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, CTL11, CTL00, CTL00, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 8'hFF, CTL00, CTL00, CTL00, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h55, 8'hFF, 8'h00,
                   10'b0100000000, 10'b1000000000, 10'b0100110011, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h55, 8'hFF,
                   10'b1000000000, 10'b0100110011, 10'b0100000000, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'hAA, 8'hAA,
                   10'b1000110011, 10'b1000110011, 10'b0111111111, 1'b1};

        cyc = 0; n_vec = 0; n_err = 0;
        mc0 = 0; mc1 = 0; mc2 = 0; prev_de = 1'b0;
        reset = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk10("reset_ch0", ch0, CTL00);
        chk10("reset_ch1", ch1, CTL00);
        chk10("reset_ch2", ch2, CTL00);
        chk10("reset_de", {9'd0, tde}, 10'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].r, tbl[i].g, tbl[i].b,
                  1, tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].ede);
            blank(LAT);
        end

        // Three all-zero pixels from zero disparity (-8, +2, -6), then DE fall.
        blank(1);
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'b0100000000, 10'b0100000000, 10'b0100000000, 1);
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'b1111111111, 10'b1111111111, 10'b1111111111, 1);
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 10'b0100000000, 10'b0100000000, 10'b0100000000, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, CTL00, CTL00, CTL00, 0);
        blank(LAT + 1);

        chk10("inv_ch0", inv0, CTL00);
        chk10("inv_ch1", inv1, CTL01);
        chk10("inv_ch2", inv2, CTL00);

        run_frame(40, 64, 24, 20);
        blank(LAT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
